pwm_carrier_cmp: RTL



---
 rtl/pwm_carrier_cmp.sv | 63 ++++++
 1 files changed

// File: rtl/pwm_carrier_cmp.sv
// pwm_carrier_cmp: sawtooth/triangle carrier with double-buffered period and compare,
// registered PWM compare output and zero/peak carrier events.
module pwm_carrier_cmp #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 carr_en,
   input  logic                 carr_mode,
   input  logic [1:0]           upd_mode,
   input  logic [CNT_WIDTH-1:0] period,
   input  logic [CNT_WIDTH-1:0] cmp,
   input  logic [CNT_WIDTH-1:0] phase,
   input  logic                 sync_in,
   output logic                 pwm,
   output logic [CNT_WIDTH-1:0] carrier,
   output logic                 dir,
   output logic                 zero_evt,
   output logic                 peak_evt
);
   logic [CNT_WIDTH-1:0] p_act, c_act, start, up, dn, car_nxt;
   logic                 dir_nxt, load, at_top;
   assign start    = phase < p_act ? phase : p_act;
   assign up       = carrier + CNT_WIDTH'(1);
   assign dn       = carrier == '0 ? '0 : carrier - CNT_WIDTH'(1);
   assign at_top   = carrier >= p_act;
   assign zero_evt = carr_en & ~reset & (carrier == '0);
   assign peak_evt = carr_en & ~reset & (carrier == p_act);
   assign load     = ~carr_en | (upd_mode == 2'd0) | (upd_mode[0] & zero_evt) | (upd_mode[1] & peak_evt);
   // at_top (>=) also covers a period shrunk below the running count
   always_comb begin
      car_nxt = start;
      dir_nxt = 1'b0;
      if (carr_en & sync_in)
         dir_nxt = carr_mode & (phase >= p_act);
      else if (carr_en & ~carr_mode)
         car_nxt = at_top ? '0 : up;
      else if (carr_en & ~dir) begin
         dir_nxt = at_top;
         car_nxt = at_top ? dn : up;
      end else if (carr_en) begin
         dir_nxt = carrier != '0;
         car_nxt = carrier != '0 ? dn : (p_act == '0 ? '0 : CNT_WIDTH'(1));
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carrier <= '0;
         dir     <= 1'b0;
         pwm     <= 1'b0;
         p_act   <= '0;
         c_act   <= '0;
      end else begin
         carrier <= car_nxt;
         dir     <= dir_nxt;
         pwm     <= carr_en & (carrier < c_act);
         if (load) begin
            p_act <= period;
            c_act <= cmp;
         end
      end
   end
endmodule
